mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data and address width in bits; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port if_req_i, input, 1 bit: instruction-fetch read request, held high until if_ack_o.
REQ-005 The block SHALL have port if_addr_i, input, WIDTH bits: fetch byte address.
REQ-006 The block SHALL have port if_ack_o, output, 1 bit: one-cycle fetch completion.
REQ-007 The block SHALL have port if_rdata_o, output, WIDTH bits: fetched word, valid only while if_ack_o=1.
REQ-008 The block SHALL have port d_req_i, input, 1 bit: data-port request, held high until d_ack_o.
REQ-009 The block SHALL have port d_we_i, input, 1 bit: 1=store, 0=load.
REQ-010 The block SHALL have port d_memtype_i, input, 2 bits: 01=byte, 10=half, other=word.
REQ-011 The block SHALL have ports d_addr_i and d_wdata_i, inputs, WIDTH bits each: data byte address and store data (low bits used for byte/half).
REQ-012 The block SHALL have ports d_ack_o (1 bit), d_err_o (1 bit) and d_rdata_o (WIDTH bits), outputs: completion, misalignment flag and raw aligned RAM word (lane extraction is done downstream).
REQ-013 The block SHALL have ports ram_en_o (1), ram_we_o (1), ram_be_o (4), ram_addr_o (WIDTH) and ram_wdata_o (WIDTH), outputs, all registered.
REQ-014 The block SHALL have port ram_rdata_i, input, WIDTH bits, from a single-port synchronous RAM with read data valid the cycle after ram_en_o=1.

Function
REQ-015 The FSM SHALL have states IDLE, ACC and RESP; transitions are IDLE->ACC on a grant, ACC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016 In IDLE with exactly one requester high, the block SHALL grant that requester.
REQ-017 In IDLE with both requesters high, the block SHALL grant the requester not granted last (round-robin); last_grant updates on every grant.
REQ-018 On grant, the block SHALL register the winner's address, we, memtype and wdata; requester inputs are ignored until the next IDLE.
REQ-019 In ACC, the block SHALL drive ram_en_o=1, ram_addr_o={addr[31:2],2'b00} and ram_we_o=d_we_i for data grants (0 for fetch grants); in IDLE and RESP it SHALL drive ram_en_o=0 and ram_we_o=0.
REQ-020 For a data store, ram_be_o SHALL be: byte 0001<<addr[1:0]; half 0011 when addr[1]=0 and 1100 when addr[1]=1; word 1111.
REQ-021 For a data store, ram_wdata_o SHALL be: byte wdata[7:0] replicated 4x; half wdata[15:0] replicated 2x; word wdata.
REQ-022 For reads, ram_be_o SHALL be 1111.
REQ-023 In RESP, the block SHALL assert exactly the granted ack for one cycle, with rdata_o=ram_rdata_i for loads/fetches (stores ack with rdata don't-care).
REQ-024 Misaligned data access (half with addr[0]=1, word with addr[1:0]!=00) SHALL take the same IDLE->ACC->RESP path with ram_en_o=0 in ACC, and SHALL assert d_err_o with d_ack_o in RESP.
REQ-025 Fetch addresses SHALL never flag an error; addr[1:0] is ignored.
REQ-026 Latency SHALL be: request seen at edge E0 in IDLE, ack during the cycle after E1, back in IDLE at E2 (3 cycles per access).
REQ-027 A request still high in IDLE after its ack SHALL be treated as a new request.
REQ-028 d_err_o SHALL be 0 whenever d_ack_o=0.
REQ-029 if_ack_o and d_ack_o SHALL never be high together.

Reset
REQ-030 While rst=1, the block SHALL hold state=IDLE, last_grant=fetch, all acks/err/ram_en_o/ram_we_o=0, ram_be_o=0000, ram_addr_o=0, ram_wdata_o=0 and rdata outputs=0.
REQ-031 Reset asserted in ACC or RESP SHALL abort the access immediately with no ack; the aborted requester SHALL be re-served after release if still requesting.
REQ-032 In the first IDLE after reset with both requesters high, the block SHALL grant data first.

Verification
REQ-033 Fetch only, if_addr=0x10, RAM word 0xDEADBEEF -> ram_en_o=1 in ACC with ram_addr_o=0x10; if_ack_o=1 with if_rdata_o=0xDEADBEEF two edges later.
REQ-034 Byte store, addr=0x23, wdata=0x000000AB -> ram_we_o=1, ram_be_o=1000, ram_wdata_o=0xABABABAB, ram_addr_o=0x20; d_ack_o=1, d_err_o=0.
REQ-035 Both requesters held high for 4 grants after reset -> grant order data, fetch, data, fetch; no overlapping acks.
REQ-036 Half load at addr=0x101 -> ram_en_o stays 0; d_ack_o=1 and d_err_o=1 in RESP.
REQ-037 rst pulsed during ACC of a data load -> no d_ack_o; outputs at reset values; after release, the load completes in 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single-port synchronous RAM. One access at a time, three cycles each:
// IDLE (grant) -> ACC (RAM enabled) -> RESP (ack with RAM read data).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req_i/if_addr_i       fetch request (held until if_ack_o) and byte address
//   if_ack_o/if_rdata_o      one-cycle fetch completion and fetched word
//   d_req_i/d_we_i           data request (held until d_ack_o), 1=store
//   d_memtype_i              01=byte, 10=half, other=word
//   d_addr_i/d_wdata_i       data byte address and store data
//   d_ack_o/d_err_o          one-cycle data completion, misalignment flag
//   d_rdata_o                raw aligned RAM word for loads
//   ram_en_o/ram_we_o        registered RAM enable / write enable
//   ram_be_o                 registered byte enables
//   ram_addr_o/ram_wdata_o   registered word-aligned address / lane-replicated data
//   ram_rdata_i              RAM read data, valid the cycle after ram_en_o
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req_i,
    input  logic [WIDTH-1:0] if_addr_i,
    output logic             if_ack_o,
    output logic [WIDTH-1:0] if_rdata_o,
    input  logic             d_req_i,
    input  logic             d_we_i,
    input  logic [1:0]       d_memtype_i,
    input  logic [WIDTH-1:0] d_addr_i,
    input  logic [WIDTH-1:0] d_wdata_i,
    output logic             d_ack_o,
    output logic             d_err_o,
    output logic [WIDTH-1:0] d_rdata_o,
    output logic             ram_en_o,
    output logic             ram_we_o,
    output logic [3:0]       ram_be_o,
    output logic [WIDTH-1:0] ram_addr_o,
    output logic [WIDTH-1:0] ram_wdata_o,
    input  logic [WIDTH-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t state, state_nxt;

    logic             last_d;   // 1: last grant went to the data port
    logic             gnt_d_q;  // requester of the access in flight
    logic             err_q;    // access in flight is a misaligned data access

    logic             gnt;
    logic             sel_d;
    logic [WIDTH-1:0] addr_sel;
    logic             is_byte, is_half, is_store;
    logic             mis;
    logic [3:0]       be;
    logic [WIDTH-1:0] wdata;

    // Grant decision, evaluated on inputs while IDLE. With both requesting,
    // data wins unless it won last time; last_d resets to 0 so data goes first.
    assign gnt      = if_req_i | d_req_i;
    assign sel_d    = d_req_i & (~if_req_i | ~last_d);
    assign addr_sel = sel_d ? d_addr_i : if_addr_i;
    assign is_byte  = (d_memtype_i == 2'b01);
    assign is_half  = (d_memtype_i == 2'b10);
    assign is_store = sel_d & d_we_i;

    // Fetch addresses never fault: misalignment only qualifies data grants.
    assign mis = sel_d & ((is_half & addr_sel[0]) |
                          (~is_byte & ~is_half & (addr_sel[1:0] != 2'b00)));

    always_comb begin
        be    = 4'b1111;
        wdata = d_wdata_i;
        if (is_store) begin
            if (is_byte) begin
                be    = 4'b0001 << addr_sel[1:0];
                wdata = {4{d_wdata_i[7:0]}};
            end else if (is_half) begin
                be    = addr_sel[1] ? 4'b1100 : 4'b0011;
                wdata = {2{d_wdata_i[15:0]}};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt) state_nxt = ACC;
            ACC:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RAM controls are registered at the grant edge so they are valid for
    // exactly the ACC cycle; en/we drop back to 0 on every other edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d      <= 1'b0;
            gnt_d_q     <= 1'b0;
            err_q       <= 1'b0;
            ram_en_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_be_o    <= 4'b0000;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
        end else begin
            ram_en_o <= 1'b0;
            ram_we_o <= 1'b0;
            if (state == IDLE && gnt) begin
                last_d      <= sel_d;
                gnt_d_q     <= sel_d;
                err_q       <= mis;
                ram_en_o    <= ~mis;
                ram_we_o    <= is_store & ~mis;
                ram_be_o    <= be;
                ram_addr_o  <= {addr_sel[WIDTH-1:2], 2'b00};
                ram_wdata_o <= wdata;
            end
        end
    end

    assign if_ack_o   = (state == RESP) & ~gnt_d_q;
    assign d_ack_o    = (state == RESP) & gnt_d_q;
    assign d_err_o    = d_ack_o & err_q;
    assign if_rdata_o = if_ack_o ? ram_rdata_i : '0;
    assign d_rdata_o  = d_ack_o ? ram_rdata_i : '0;

endmodule
